// File: rtl/instr_rom_server.sv
// instr_rom_server: responder end of the fetch-stage instruction-memory interface.
// Returns the 32-bit word at a byte address after a fixed LATENCY and pulses
// completed. A loader port can write the word array on any cycle.
// Optional build macro: IROM_RANGE_CHECK_EN. When it is defined, requests with
// upper address bits set return a nop and raise fault.
module instr_rom_server #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req,
    input  logic [31:0]           addr,
    output logic                  completed,
    output logic [31:0]           data,
    output logic                  busy,
    output logic                  fault,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [31:0]      NOP_WORD = 32'h0000_0013;

    // The latency counter is only 4 bits wide, so LATENCY must be 1..15.
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("instr_rom_server: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    oob;
    logic [31:0]             mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   addr_idx_c;
    logic                    addr_oob_c;
    logic                    unused_addr_c;
    logic [ADDR_WIDTH-1:0]   rd_idx_c;
    logic                    rd_oob_c;
    logic [31:0]             rd_word_c;
    logic [31:0]             fetch_word_c;

    assign addr_idx_c = addr[ADDR_WIDTH+1:2];

`ifdef IROM_RANGE_CHECK_EN
    assign addr_oob_c    = |addr[31:ADDR_WIDTH+2];
    assign unused_addr_c = ^addr[1:0];
`else
    assign addr_oob_c    = 1'b0;
    assign unused_addr_c = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
`endif

    // Read source: live address while IDLE (LATENCY=1 captures at acceptance), latched index otherwise.
    always_comb begin
        rd_idx_c     = idx;
        rd_oob_c     = oob;
        if (state == IDLE) begin
            rd_idx_c = addr_idx_c;
            rd_oob_c = addr_oob_c;
        end
        // Forward a same-edge loader write so any write before the READ cycle is seen.
        rd_word_c    = (ld_we && (ld_addr == rd_idx_c)) ? ld_data : mem[rd_idx_c];
        fetch_word_c = rd_oob_c ? NOP_WORD : rd_word_c;
    end

    // Loader write port; array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Fetch FSM with registered completion, fault, busy and data outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            oob       <= 1'b0;
            completed <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            data      <= '0;
        end else begin
            completed <= 1'b0;
            fault     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        idx  <= addr_idx_c;
                        oob  <= addr_oob_c;
                        busy <= 1'b1;
                        if (LATENCY == 1) begin
                            data      <= fetch_word_c;
                            completed <= 1'b1;
                            fault     <= rd_oob_c;
                            cnt       <= '0;
                            state     <= READ;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        data      <= fetch_word_c;
                        completed <= 1'b1;
                        fault     <= rd_oob_c;
                        cnt       <= '0;
                        state     <= READ;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                READ: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_rom_server.sv
// Self-checking bench for instr_rom_server: one instance at LATENCY=2 and one at
// LATENCY=1, sharing the loader bus. Expected words are queued when a request is
// driven and compared when completed pulses.
module tb_instr_rom_server;

    localparam int unsigned AW = 12;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        req, req1;
    logic [31:0] addr, addr1;
    logic        ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0] ld_data;

    logic        completed, busy, fault;
    logic [31:0] data;
    logic        completed1, busy1, fault1;
    logic [31:0] data1;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int unsigned due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

`ifdef IROM_RANGE_CHECK_EN
    localparam logic [31:0] OOB_DATA  = 32'h0000_0013;
    localparam logic        OOB_FAULT = 1'b1;
`else
    localparam logic [31:0] OOB_DATA  = 32'hA5A5_0000;
    localparam logic        OOB_FAULT = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    instr_rom_server #(.ADDR_WIDTH(AW), .LATENCY(2)) u_dut (
        .clk(clk), .rstn(rstn), .req(req), .addr(addr),
        .completed(completed), .data(data), .busy(busy), .fault(fault),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    instr_rom_server #(.ADDR_WIDTH(AW), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rstn(rstn), .req(req1), .addr(addr1),
        .completed(completed1), .data(data1), .busy(busy1), .fault(fault1),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ld(input logic [AW-1:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    // One-cycle request to the LATENCY=2 instance; returns in the cycle after acceptance.
    task automatic fetch0(input logic [31:0] a, input logic [31:0] d, input logic f, input bit expect_done);
        exp_t e;
        req = 1'b1; addr = a;
        if (expect_done) begin
            e.data = d; e.fault = f; e.due = cyc + 2;
            q0.push_back(e);
        end
        tick();
        req = 1'b0; addr = $urandom;
    endtask

    task automatic fetch1(input logic [31:0] a, input logic [31:0] d, input logic f);
        exp_t e;
        req1 = 1'b1; addr1 = a;
        e.data = d; e.fault = f; e.due = cyc + 1;
        q1.push_back(e);
        tick();
        req1 = 1'b0; addr1 = $urandom;
    endtask

    // Scoreboard for the LATENCY=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && completed) begin
            if (q0.size() == 0) check("spurious_completed0", 32'(completed), 32'd0);
            else begin
                e = q0.pop_front();
                check("data0", data, e.data);
                check("fault0", 32'(fault), 32'(e.fault));
                check("latency0", cyc, e.due);
                check("busy_at_done0", 32'(busy), 32'd1);
            end
        end
    end

    // Scoreboard for the LATENCY=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && completed1) begin
            if (q1.size() == 0) check("spurious_completed1", 32'(completed1), 32'd0);
            else begin
                e = q1.pop_front();
                check("data1", data1, e.data);
                check("fault1", 32'(fault1), 32'(e.fault));
                check("latency1", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req = 1'b0; req1 = 1'b0; addr = '0; addr1 = '0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        tick(2);
        check("rst_completed", 32'(completed), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_data", data, 32'd0);
        rstn = 1'b1;
        tick();

        ld(12'd5, 32'hDEAD_BEEF);
        ld(12'd6, 32'h1234_5678);
        ld(12'd0, 32'hA5A5_0000);
        ld(12'd4095, 32'hCAFE_F00D);

        // Basic fetch, busy across the wait and completion cycles.
        fetch0(32'h14, 32'hDEAD_BEEF, 1'b0, 1'b1);
        check("busy_wait", 32'(busy), 32'd1);
        check("completed_early", 32'(completed), 32'd0);
        tick();
        tick();
        check("busy_idle", 32'(busy), 32'd0);

        // Back-to-back request, plus req held while busy must be ignored.
        fetch0(32'h18, 32'h1234_5678, 1'b0, 1'b1);
        req = 1'b1; addr = 32'h14;
        tick(2);
        req = 1'b0;
        tick(4);
        check("data_held", data, 32'h1234_5678);

        // Loader write before READ is visible.
        fetch0(32'h14, 32'h1111_1111, 1'b0, 1'b1);
        ld(12'd5, 32'h1111_1111);
        tick(2);
        ld(12'd5, 32'hDEAD_BEEF);
        // Loader write in the READ cycle returns the old word.
        fetch0(32'h14, 32'hDEAD_BEEF, 1'b0, 1'b1);
        tick();
        ld(12'd5, 32'h2222_2222);
        tick(2);
        ld(12'd5, 32'hDEAD_BEEF);

        // Reset mid-operation aborts the request.
        fetch0(32'h18, 32'h0, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", data, 32'd0);
        check("abort_completed", 32'(completed), 32'd0);
        tick();
        rstn = 1'b1;
        tick(4);
        fetch0(32'h14, 32'hDEAD_BEEF, 1'b0, 1'b1);
        tick(3);

        // LATENCY=1: misaligned address, then back-to-back.
        fetch1(32'h17, 32'hDEAD_BEEF, 1'b0);
        check("l1_busy", 32'(busy1), 32'd1);
        tick();
        fetch1(32'h18, 32'h1234_5678, 1'b0);
        tick(3);

        // Top in-range word, then an out-of-range address on both instances.
        fetch0(32'h3FFC, 32'hCAFE_F00D, 1'b0, 1'b1);
        tick(3);
        fetch0(32'h0001_0000, OOB_DATA, OOB_FAULT, 1'b1);
        fetch1(32'h0001_0000, OOB_DATA, OOB_FAULT);
        tick(4);
        check("fault_clears", 32'(fault), 32'd0);

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
